// File: rtl/idex_pkg.sv
// Shared types and default widths for the ID/EX pipeline register.
package idex_pkg;

  localparam int DATA_W = 16;
  localparam int REG_W  = 4;
  localparam int CTRL_W = 16;

  typedef struct packed {
    logic [DATA_W-1:0] d1;
    logic [DATA_W-1:0] d2;
    logic [DATA_W-1:0] d15;
    logic [REG_W-1:0]  rs;
    logic [REG_W-1:0]  rt1;
    logic [REG_W-1:0]  rt2;
    logic [REG_W-1:0]  rd;
    logic [CTRL_W-1:0] ctrl;
  } idex_t;

  localparam idex_t IDEX_RESET = '0;

endpackage

// File: rtl/buffer_idex_pipe_reg.sv
// Width-parameterised pipeline register: sync reset, then clear, then hold, else load.
module pipe_reg #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         hold,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] q_p1;

  // stage boundary: decode -> execute
  always_ff @(posedge clk) begin
    if (rst) begin
      q_p1 <= '0;
    end else if (clr) begin
      q_p1 <= '0;
    end else if (!hold) begin
      q_p1 <= d;
    end
  end

  assign q = q_p1;

endmodule

// File: rtl/buffer_idex.sv
// ID/EX pipeline register of the 16-bit datapath, one pipe_reg per field.
// Optional Stall/Flush ports are enabled by defining BUFFER_IDEX_HAZARD_EN.
module buffer_idex #(
  parameter int DATA_W = idex_pkg::DATA_W,
  parameter int REG_W  = idex_pkg::REG_W,
  parameter int CTRL_W = idex_pkg::CTRL_W
) (
  output logic [DATA_W-1:0] OD1,
  output logic [DATA_W-1:0] OD2,
  output logic [DATA_W-1:0] OD15,
  output logic [REG_W-1:0]  ORS,
  output logic [REG_W-1:0]  ORT1,
  output logic [REG_W-1:0]  ORT2,
  output logic [REG_W-1:0]  ORD,
  output logic [CTRL_W-1:0] OC,
  input  logic [DATA_W-1:0] ID1,
  input  logic [DATA_W-1:0] ID2,
  input  logic [DATA_W-1:0] ID15,
  input  logic [REG_W-1:0]  IRS,
  input  logic [REG_W-1:0]  IRT1,
  input  logic [REG_W-1:0]  IRT2,
  input  logic [REG_W-1:0]  IRD,
  input  logic [CTRL_W-1:0] IC,
  input  logic              C,
  input  logic              R
`ifdef BUFFER_IDEX_HAZARD_EN
  ,
  input  logic              Stall,
  input  logic              Flush
`endif
);

  logic hold;
  logic clr;

`ifdef BUFFER_IDEX_HAZARD_EN
  assign hold = Stall;
  assign clr  = Flush;
`else
  assign hold = 1'b0;
  assign clr  = 1'b0;
`endif

  // Flush beats Stall because pipe_reg tests clear before hold.
  pipe_reg #(.W(DATA_W)) u_d1   (.clk(C), .rst(R), .hold(hold), .clr(clr), .d(ID1),  .q(OD1));
  pipe_reg #(.W(DATA_W)) u_d2   (.clk(C), .rst(R), .hold(hold), .clr(clr), .d(ID2),  .q(OD2));
  pipe_reg #(.W(DATA_W)) u_d15  (.clk(C), .rst(R), .hold(hold), .clr(clr), .d(ID15), .q(OD15));
  pipe_reg #(.W(REG_W))  u_rs   (.clk(C), .rst(R), .hold(hold), .clr(clr), .d(IRS),  .q(ORS));
  pipe_reg #(.W(REG_W))  u_rt1  (.clk(C), .rst(R), .hold(hold), .clr(clr), .d(IRT1), .q(ORT1));
  pipe_reg #(.W(REG_W))  u_rt2  (.clk(C), .rst(R), .hold(hold), .clr(clr), .d(IRT2), .q(ORT2));
  pipe_reg #(.W(REG_W))  u_rd   (.clk(C), .rst(R), .hold(hold), .clr(clr), .d(IRD),  .q(ORD));
  pipe_reg #(.W(CTRL_W)) u_ctrl (.clk(C), .rst(R), .hold(hold), .clr(clr), .d(IC),   .q(OC));

endmodule

// File: tb/tb_buffer_idex.sv
// Scoreboard bench for buffer_idex: driver queues expected outputs, monitor compares.
module tb_buffer_idex;
  import idex_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] od1, od2, od15, oc, id1, id2, id15, ic;
  logic [3:0]  ors, ort1, ort2, ord, irs, irt1, irt2, ird;
  logic        r, stall, flush;

  buffer_idex dut (
    .OD1(od1), .OD2(od2), .OD15(od15), .ORS(ors), .ORT1(ort1), .ORT2(ort2),
    .ORD(ord), .OC(oc), .ID1(id1), .ID2(id2), .ID15(id15), .IRS(irs),
    .IRT1(irt1), .IRT2(irt2), .IRD(ird), .IC(ic), .C(clk), .R(r)
`ifdef BUFFER_IDEX_HAZARD_EN
    , .Stall(stall), .Flush(flush)
`endif
  );

  idex_t sb_q[$];
  int    checks = 0;
  int    errors = 0;
  logic  done = 1'b0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one word set, let one edge pass, then queue what the outputs must be.
  task automatic cyc(input idex_t in, input logic rr, input logic st, input logic fl,
                     input idex_t exp);
    id1 = in.d1; id2 = in.d2; id15 = in.d15; irs = in.rs; irt1 = in.rt1;
    irt2 = in.rt2; ird = in.rd; ic = in.ctrl; r = rr; stall = st; flush = fl;
    @(posedge clk);
    #1;
    sb_q.push_back(exp);
  endtask

  always @(negedge clk) begin
    while (sb_q.size() > 0) begin
      idex_t e;
      e = sb_q.pop_front();
      chk("od1",  od1,  e.d1);
      chk("od2",  od2,  e.d2);
      chk("od15", od15, e.d15);
      chk("ors",  {12'h0, ors},  {12'h0, e.rs});
      chk("ort1", {12'h0, ort1}, {12'h0, e.rt1});
      chk("ort2", {12'h0, ort2}, {12'h0, e.rt2});
      chk("ord",  {12'h0, ord},  {12'h0, e.rd});
      chk("oc",   oc,   e.ctrl);
    end
  end

  idex_t cur, held, z;

  initial begin
    z = IDEX_RESET;
    r = 1'b1; stall = 1'b0; flush = 1'b0;
    // Reset with arbitrary inputs.
    cur = '{d1:16'h1234, d2:16'h5678, d15:16'h9ABC, rs:4'hD, rt1:4'hE, rt2:4'hF, rd:4'h1, ctrl:16'hBEEF};
    cyc(cur, 1'b1, 1'b0, 1'b0, z);
    // Capture on the first edge with R low.
    cur = '{d1:16'h1111, d2:16'h2222, d15:16'hFFF0, rs:4'h1, rt1:4'h2, rt2:4'h7, rd:4'h4, ctrl:16'h0FFF};
    cyc(cur, 1'b0, 1'b0, 1'b0,
        '{d1:16'h1111, d2:16'h2222, d15:16'hFFF0, rs:4'h1, rt1:4'h2, rt2:4'h7, rd:4'h4, ctrl:16'h0FFF});
    // Staggered single-field updates.
    cur.d1 = 16'h0A01; cyc(cur, 1'b0, 1'b0, 1'b0,
        '{d1:16'h0A01, d2:16'h2222, d15:16'hFFF0, rs:4'h1, rt1:4'h2, rt2:4'h7, rd:4'h4, ctrl:16'h0FFF});
    cur.d2 = 16'h00B3; cyc(cur, 1'b0, 1'b0, 1'b0,
        '{d1:16'h0A01, d2:16'h00B3, d15:16'hFFF0, rs:4'h1, rt1:4'h2, rt2:4'h7, rd:4'h4, ctrl:16'h0FFF});
    cur.d15 = 16'h000F; cyc(cur, 1'b0, 1'b0, 1'b0,
        '{d1:16'h0A01, d2:16'h00B3, d15:16'h000F, rs:4'h1, rt1:4'h2, rt2:4'h7, rd:4'h4, ctrl:16'h0FFF});
    cur.rs = 4'hE; cyc(cur, 1'b0, 1'b0, 1'b0,
        '{d1:16'h0A01, d2:16'h00B3, d15:16'h000F, rs:4'hE, rt1:4'h2, rt2:4'h7, rd:4'h4, ctrl:16'h0FFF});
    cur.rt1 = 4'h5; cur.ctrl = 16'h0000; cyc(cur, 1'b0, 1'b0, 1'b0,
        '{d1:16'h0A01, d2:16'h00B3, d15:16'h000F, rs:4'hE, rt1:4'h5, rt2:4'h7, rd:4'h4, ctrl:16'h0000});
    cur.rt2 = 4'h3; cyc(cur, 1'b0, 1'b0, 1'b0,
        '{d1:16'h0A01, d2:16'h00B3, d15:16'h000F, rs:4'hE, rt1:4'h5, rt2:4'h3, rd:4'h4, ctrl:16'h0000});
    cur.rd = 4'h2; cyc(cur, 1'b0, 1'b0, 1'b0,
        '{d1:16'h0A01, d2:16'h00B3, d15:16'h000F, rs:4'hE, rt1:4'h5, rt2:4'h3, rd:4'h2, ctrl:16'h0000});
    // Mid-stream reset with every field nonzero, then resume.
    cur = '{d1:16'hA5A5, d2:16'h5A5A, d15:16'h8001, rs:4'h9, rt1:4'hA, rt2:4'hB, rd:4'hC, ctrl:16'h00C3};
    cyc(cur, 1'b0, 1'b0, 1'b0,
        '{d1:16'hA5A5, d2:16'h5A5A, d15:16'h8001, rs:4'h9, rt1:4'hA, rt2:4'hB, rd:4'hC, ctrl:16'h00C3});
    cyc(cur, 1'b1, 1'b0, 1'b0, z);
    cur.d1 = 16'h7777;
    cyc(cur, 1'b0, 1'b0, 1'b0,
        '{d1:16'h7777, d2:16'h5A5A, d15:16'h8001, rs:4'h9, rt1:4'hA, rt2:4'hB, rd:4'hC, ctrl:16'h00C3});
    held = '{d1:16'h7777, d2:16'h5A5A, d15:16'h8001, rs:4'h9, rt1:4'hA, rt2:4'hB, rd:4'hC, ctrl:16'h00C3};
`ifdef BUFFER_IDEX_HAZARD_EN
    // Stall for two edges while the inputs keep changing.
    cur = '{d1:16'h0001, d2:16'h0002, d15:16'h0003, rs:4'h4, rt1:4'h5, rt2:4'h6, rd:4'h7, ctrl:16'h0008};
    cyc(cur, 1'b0, 1'b1, 1'b0, held);
    cur = '{d1:16'hF001, d2:16'hF002, d15:16'hF003, rs:4'h1, rt1:4'h2, rt2:4'h3, rd:4'h5, ctrl:16'hF008};
    cyc(cur, 1'b0, 1'b1, 1'b0, held);
    // Release stall: capture resumes.
    cyc(cur, 1'b0, 1'b0, 1'b0,
        '{d1:16'hF001, d2:16'hF002, d15:16'hF003, rs:4'h1, rt1:4'h2, rt2:4'h3, rd:4'h5, ctrl:16'hF008});
    // Flush beats Stall.
    cyc(cur, 1'b0, 1'b1, 1'b1, z);
    cyc(cur, 1'b0, 1'b0, 1'b0,
        '{d1:16'hF001, d2:16'hF002, d15:16'hF003, rs:4'h1, rt1:4'h2, rt2:4'h3, rd:4'h5, ctrl:16'hF008});
    // Reset beats Stall.
    cyc(cur, 1'b1, 1'b1, 1'b0, z);
    cyc(cur, 1'b0, 1'b0, 1'b0,
        '{d1:16'hF001, d2:16'hF002, d15:16'hF003, rs:4'h1, rt1:4'h2, rt2:4'h3, rd:4'h5, ctrl:16'hF008});
    // Flush alone clears.
    cyc(cur, 1'b0, 1'b0, 1'b1, z);
`else
    // Without hazard ports every edge loads.
    cur = '{d1:16'h0001, d2:16'h0002, d15:16'h0003, rs:4'h4, rt1:4'h5, rt2:4'h6, rd:4'h7, ctrl:16'h0008};
    cyc(cur, 1'b0, 1'b0, 1'b0,
        '{d1:16'h0001, d2:16'h0002, d15:16'h0003, rs:4'h4, rt1:4'h5, rt2:4'h6, rd:4'h7, ctrl:16'h0008});
`endif
    repeat (3) @(posedge clk);
    done = 1'b1;
  end

  initial begin
    fork
      wait (done);
      begin
        #20000;
        errors++;
        $display("FAIL timeout got no-completion expected completion");
      end
    join_any
    disable fork;
    @(negedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain got %0d expected 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
